// File: rtl/dii_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one DII flit stream among PORTS sources.
// Optional per-port saturating packet counters are built when DII_ARB_PKTCNT_EN is defined.
module dii_packet_arbiter #(
  parameter int unsigned PORTS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    port_en_i,
  input  logic [PORTS-1:0]    flit_in_valid_i,
  input  logic [PORTS-1:0]    flit_in_last_i,
  input  logic [PORTS*16-1:0] flit_in_data_i,
  output logic [PORTS-1:0]    flit_in_ready_o,
  output logic                flit_out_valid_o,
  output logic                flit_out_last_o,
  output logic [15:0]         flit_out_data_o,
  input  logic                flit_out_ready_i,
`ifdef DII_ARB_PKTCNT_EN
  output logic [PORTS*16-1:0] pkt_count_o,
`endif
  output logic [PORTS-1:0]    grant_o
);

  localparam int unsigned PtrW = $clog2(PORTS);
  typedef logic [PtrW-1:0] ptr_t;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  ptr_t             owner_q, owner_d;
  ptr_t             rr_ptr_q, rr_ptr_d;

  logic [PORTS-1:0] req;
  logic             found;
  ptr_t             pick;
  logic             last_fire;
  logic [15:0]      data_arr [PORTS];

  always_comb begin
    for (int i = 0; i < int'(PORTS); i++) begin
      data_arr[i] = flit_in_data_i[i*16 +: 16];
    end
  end

  // Search upward from rr_ptr with an explicit wrap so non-power-of-2 PORTS works.
  always_comb begin : p_arb
    int unsigned idx;
    idx   = 0;
    req   = flit_in_valid_i & port_en_i;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= PORTS) begin
        idx = idx - PORTS;
      end
      if (!found && req[ptr_t'(idx)]) begin
        found = 1'b1;
        pick  = ptr_t'(idx);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    flit_out_valid_o = 1'b0;
    flit_out_last_o  = 1'b0;
    flit_out_data_o  = '0;
    flit_in_ready_o  = '0;
    last_fire        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d       = StGrant;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      StGrant: begin
        flit_out_valid_o = flit_in_valid_i[owner_q];
        flit_out_last_o  = flit_in_last_i[owner_q];
        flit_out_data_o  = data_arr[owner_q];
        flit_in_ready_o  = grant_q & {PORTS{flit_out_ready_i}};
        last_fire        = flit_in_valid_i[owner_q] & flit_in_last_i[owner_q] & flit_out_ready_i;
        if (last_fire) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = (owner_q == ptr_t'(PORTS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_o = grant_q;

`ifdef DII_ARB_PKTCNT_EN
  logic [PORTS-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (last_fire && (cnt_q[owner_q] != 16'hFFFF)) begin
      cnt_d[owner_q] = cnt_q[owner_q] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_count_o = cnt_q;
`endif

endmodule
